// File: rtl/dstream_pkg.sv
// Shared dstream types and helpers. Build option: DSTREAM_FIFO_HWM_EN enables
// the FIFO high-water-mark port.
`ifndef DSTREAM_PKG_SV
`define DSTREAM_PKG_SV
`define DSTREAM_DWORD_T(W) logic [(W)-1:0]

package dstream_pkg;

  localparam int DSTREAM_W_DEFAULT = 30;

  typedef logic [DSTREAM_W_DEFAULT-1:0] dword_t;

  // Pointer width for a storage depth; a single-word store still needs one bit.
  function automatic int clog2_depth(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage
`endif

// File: rtl/dstream_if.sv
// dstream valid/ready/data bundle; "in" is the consumer view, "out" the producer view.
interface dstream #(
  parameter int N = 30
);
  logic                 valid;
  logic                 ready;
  `DSTREAM_DWORD_T(N)   data;

  modport in  (input valid, input data, output ready);
  modport out (output valid, output data, input ready);
endinterface

// File: rtl/dstream_fifo.sv
// Synchronous dstream FIFO with registered-state ready. Optional high-water
// mark output is enabled with DSTREAM_FIFO_HWM_EN.
module dstream_fifo
  import dstream_pkg::*;
#(
  parameter  int N     = DSTREAM_W_DEFAULT,
  parameter  int DEPTH = 8,
  localparam int PW    = clog2_depth(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  dstream.in            x,
  dstream.out           y,
  output logic [CW-1:0] count
`ifdef DSTREAM_FIFO_HWM_EN
  ,
  output logic [CW-1:0] hwm
`endif
);

  `DSTREAM_DWORD_T(N) mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Ready looks only at registered occupancy, so y.ready never reaches x.ready.
  assign x.ready = !reset && (count_q != CW'(DEPTH));
  assign y.valid = (count_q != '0);
  assign y.data  = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    push     = x.valid && x.ready;
    pop      = y.valid && y.ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; push is already blocked during reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= x.data;
  end

`ifdef DSTREAM_FIFO_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = (count_q > hwm_q) ? count_q : hwm_q;
  end

  always_ff @(posedge clk) begin
    if (reset) hwm_q <= '0;
    else       hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_dstream_fifo.sv
// Scoreboard bench for dstream_fifo (N=30, DEPTH=8); high-water-mark scenario
// runs only when DSTREAM_FIFO_HWM_EN is defined.
module tb_dstream_fifo;
  localparam int N     = 30;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] count;
`ifdef DSTREAM_FIFO_HWM_EN
  logic [CW-1:0] hwm;
`endif

  dstream #(.N(N)) x_if ();
  dstream #(.N(N)) y_if ();

  dstream_fifo #(.N(N), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .x     (x_if),
    .y     (y_if),
    .count (count)
`ifdef DSTREAM_FIFO_HWM_EN
    ,
    .hwm   (hwm)
`endif
  );

  always #5 clk = ~clk;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [N-1:0] exp_q [$];

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic xv, input logic [N-1:0] xd, input logic yr);
    @(negedge clk);
    x_if.valid = xv;
    x_if.data  = xd;
    y_if.ready = yr;
    #1;
  endtask

  // Reference model step for the upcoming rising edge.
  task automatic advance();
    bit can_push, can_pop;
    can_push = (exp_q.size() != DEPTH);
    can_pop  = (exp_q.size() != 0);
    if (can_pop && y_if.ready) void'(exp_q.pop_front());
    if (can_push && x_if.valid) exp_q.push_back(x_if.data);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, N'('h55), 1'b0);
      total_cnt++;
      if (x_if.ready !== 1'b0 || y_if.valid !== 1'b0 || count !== '0)
        $display("[TB] FAIL reset_hold cyc%0d: ready=%b valid=%b count=%0d, need 0/0/0",
                 i, x_if.ready, y_if.valid, count);
      else pass_cnt++;
    end
    @(negedge clk);
    reset = 1'b0;
    x_if.valid = 1'b0;
    #1;
    exp_q.delete();
    drive(1'b0, '0, 1'b0);
    total_cnt++;
    if (x_if.ready !== 1'b1 || y_if.valid !== 1'b0 || count !== '0)
      $display("[TB] FAIL reset_release: ready=%b valid=%b count=%0d, need 1/0/0",
               x_if.ready, y_if.valid, count);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, N'(i), 1'b0);
      total_cnt++;
      if (x_if.ready !== 1'b1 || count !== CW'(i - 1))
        $display("[TB] FAIL fill_%0d: ready=%b count=%0d, need 1/%0d",
                 i, x_if.ready, count, i - 1);
      else pass_cnt++;
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, N'('h9), 1'b0);
      total_cnt++;
      if (x_if.ready !== 1'b0 || count !== CW'(DEPTH) || y_if.valid !== 1'b1
          || y_if.data !== N'('h1))
        $display("[TB] FAIL fill_full%0d: ready=%b count=%0d valid=%b data=%h, need 0/8/1/1",
                 k, x_if.ready, count, y_if.valid, y_if.data);
      else pass_cnt++;
      advance();
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      total_cnt++;
      if (y_if.valid !== 1'b1 || y_if.data !== N'(i) || y_if.data !== exp_q[0]
          || count !== CW'(DEPTH - i + 1))
        $display("[TB] FAIL drain_%0d: valid=%b data=%h count=%0d, need 1/%h/%0d",
                 i, y_if.valid, y_if.data, count, i, DEPTH - i + 1);
      else pass_cnt++;
      advance();
    end
    drive(1'b0, '0, 1'b0);
    total_cnt++;
    if (y_if.valid !== 1'b0 || count !== '0 || exp_q.size() != 0)
      $display("[TB] FAIL drain_empty: valid=%b count=%0d, need 0/0", y_if.valid, count);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, N'('h100 + i), 1'b1);
      total_cnt++;
      if (i == 0) begin
        if (y_if.valid !== 1'b0 || count !== '0)
          $display("[TB] FAIL stream_first: valid=%b count=%0d, need 0/0", y_if.valid, count);
        else pass_cnt++;
      end else begin
        if (y_if.valid !== 1'b1 || count !== CW'(1) || y_if.data !== N'('h100 + i - 1)
            || y_if.data !== exp_q[0])
          $display("[TB] FAIL stream_%0d: valid=%b count=%0d data=%h, need 1/1/%h",
                   i, y_if.valid, count, y_if.data, 'h100 + i - 1);
        else pass_cnt++;
      end
      advance();
    end
    drive(1'b0, '0, 1'b1);
    total_cnt++;
    if (y_if.valid !== 1'b1 || y_if.data !== N'('h100 + 39))
      $display("[TB] FAIL stream_last: valid=%b data=%h, need 1/%h", y_if.valid, y_if.data, 'h100 + 39);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_random_stall();
    logic         prev_stall = 1'b0;
    logic [N-1:0] prev_data  = '0;
    int           budget;
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)));
      total_cnt++;
      if (x_if.ready !== (exp_q.size() != DEPTH) || y_if.valid !== (exp_q.size() != 0)
          || count !== CW'(exp_q.size()))
        $display("[TB] FAIL rand_flags_%0d: ready=%b valid=%b count=%0d, need count %0d",
                 i, x_if.ready, y_if.valid, count, exp_q.size());
      else pass_cnt++;
      if (exp_q.size() != 0) begin
        total_cnt++;
        if (y_if.data !== exp_q[0])
          $display("[TB] FAIL rand_order_%0d: data=%h need %h", i, y_if.data, exp_q[0]);
        else pass_cnt++;
      end
      if (prev_stall) begin
        total_cnt++;
        if (y_if.data !== prev_data)
          $display("[TB] FAIL rand_stable_%0d: data=%h need %h", i, y_if.data, prev_data);
        else pass_cnt++;
      end
      prev_stall = y_if.valid && !y_if.ready;
      prev_data  = y_if.data;
      advance();
    end
    budget = 2 * DEPTH;
    while (exp_q.size() != 0 && budget > 0) begin
      drive(1'b0, '0, 1'b1);
      total_cnt++;
      if (y_if.valid !== 1'b1 || y_if.data !== exp_q[0])
        $display("[TB] FAIL rand_drain: valid=%b data=%h need 1/%h", y_if.valid, y_if.data, exp_q[0]);
      else pass_cnt++;
      advance();
      budget--;
    end
    drive(1'b0, '0, 1'b0);
    total_cnt++;
    if (exp_q.size() != 0 || count !== '0 || y_if.valid !== 1'b0)
      $display("[TB] FAIL rand_empty: model=%0d count=%0d valid=%b, need 0/0/0",
               exp_q.size(), count, y_if.valid);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, N'('h200 + i), 1'b0);
      advance();
    end
    drive(1'b0, '0, 1'b0);
    total_cnt++;
    if (count !== CW'(5))
      $display("[TB] FAIL midrst_pre: count=%0d need 5", count);
    else pass_cnt++;
    reset = 1'b1;
    drive(1'b1, N'('h3FF), 1'b1);
    total_cnt++;
    if (x_if.ready !== 1'b0)
      $display("[TB] FAIL midrst_ready: ready=%b need 0", x_if.ready);
    else pass_cnt++;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    x_if.valid = 1'b0;
    y_if.ready = 1'b0;
    #1;
    total_cnt++;
    if (count !== '0 || y_if.valid !== 1'b0 || x_if.ready !== 1'b1)
      $display("[TB] FAIL midrst_flush: count=%0d valid=%b ready=%b, need 0/0/1",
               count, y_if.valid, x_if.ready);
    else pass_cnt++;
    drive(1'b1, N'('hA), 1'b0);
    advance();
    drive(1'b0, '0, 1'b1);
    total_cnt++;
    if (y_if.valid !== 1'b1 || y_if.data !== N'('hA) || count !== CW'(1))
      $display("[TB] FAIL midrst_first: valid=%b data=%h count=%0d, need 1/a/1",
               y_if.valid, y_if.data, count);
    else pass_cnt++;
    advance();
    drive(1'b0, '0, 1'b0);
    total_cnt++;
    if (y_if.valid !== 1'b0 || count !== '0)
      $display("[TB] FAIL midrst_after: valid=%b count=%0d, need 0/0", y_if.valid, count);
    else pass_cnt++;
  endtask

`ifdef DSTREAM_FIFO_HWM_EN
  task automatic test_hwm();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if (hwm !== '0)
      $display("[TB] FAIL hwm_reset: hwm=%0d need 0", hwm);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, N'('h300 + i), 1'b0);
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, 1'b1);
      advance();
    end
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    total_cnt++;
    if (hwm !== CW'(6) || count !== '0)
      $display("[TB] FAIL hwm_peak: hwm=%0d count=%0d, need 6/0", hwm, count);
    else pass_cnt++;
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    reset = 1'b0;
    drive(1'b0, '0, 1'b0);
    total_cnt++;
    if (hwm !== '0)
      $display("[TB] FAIL hwm_cleared: hwm=%0d need 0", hwm);
    else pass_cnt++;
  endtask
`endif

  initial begin
    reset      = 1'b1;
    x_if.valid = 1'b1;
    x_if.data  = '0;
    y_if.ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_random_stall();
    test_mid_reset();
`ifdef DSTREAM_FIFO_HWM_EN
    test_hwm();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
